// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 keyboard receiver.
//   Scan codes, prefix bytes, ignore codes, frame/decoder state types.
package ps2_pkg;

  // Game-relevant make codes
  localparam logic [7:0] S_KEY   = 8'h1B;
  localparam logic [7:0] P_KEY   = 8'h4D;
  localparam logic [7:0] R_KEY   = 8'h2D;
  localparam logic [7:0] ESC_KEY = 8'h76;
  localparam logic [7:0] UP      = 8'h75;
  localparam logic [7:0] DOWN    = 8'h72;
  localparam logic [7:0] LEFT    = 8'h6B;
  localparam logic [7:0] RIGHT   = 8'h74;

  // Sequence prefixes
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Keyboard status/ack bytes that carry no key information
  localparam logic [7:0] IGN_BAT  = 8'hAA;
  localparam logic [7:0] IGN_ACK  = 8'hFA;
  localparam logic [7:0] IGN_ECHO = 8'hEE;
  localparam logic [7:0] IGN_RSND = 8'hFE;

  // Pause sends E1 followed by seven more bytes
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [2:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_SKIP
  } dec_state_t;

  function automatic logic is_ignore_code(input logic [7:0] b);
    return (b == IGN_BAT) || (b == IGN_ACK) || (b == IGN_ECHO) || (b == IGN_RSND);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, clock glitch filter, 11-bit frame FSM
// and inter-bit timeout.
//   clk, rst_n   : system clock, async active-low reset
//   ps2_clk      : raw keyboard clock (asynchronous)
//   ps2_data     : raw keyboard data (asynchronous)
//   data_byte    : last received data byte (valid when byte_valid is high)
//   byte_valid   : one-cycle pulse, frame had odd parity and stop bit 1
//   frame_error  : one-cycle pulse on parity, stop-bit or timeout failure
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   clk_filt;
  logic                   clk_filt_d;
  logic [FW-1:0]          filt_cnt;
  logic                   sample;
  frame_state_t           state;
  logic [2:0]             bit_cnt;
  logic                   parity;
  logic [TW-1:0]          to_cnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  // Falling edge of the filtered clock marks a bit sample
  assign sample = clk_filt_d & ~clk_filt;

  // Synchroniser chains; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= (clk_sync << 1) | SYNC_STAGES'(ps2_clk);
      data_sync <= (data_sync << 1) | SYNC_STAGES'(ps2_data);
    end
  end

  // Filter: accept a new clock level only after FILTER_LEN consecutive samples of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM with timeout abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FR_IDLE;
      bit_cnt     <= '0;
      data_byte   <= '0;
      parity      <= 1'b0;
      to_cnt      <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (state != FR_IDLE && !sample && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= FR_IDLE;
        bit_cnt     <= '0;
        to_cnt      <= '0;
        frame_error <= 1'b1;
      end else begin
        if (state == FR_IDLE || sample) to_cnt <= '0;
        else                            to_cnt <= to_cnt + TW'(1);
        if (sample) begin
          case (state)
            FR_IDLE: begin
              if (!data_s) begin
                state   <= FR_DATA;
                bit_cnt <= '0;
              end
            end
            FR_DATA: begin
              data_byte <= {data_s, data_byte[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= FR_PARITY;
            end
            FR_PARITY: begin
              parity <= data_s;
              state  <= FR_STOP;
            end
            FR_STOP: begin
              // Odd parity over data+parity, and a high stop bit
              if ((^{data_byte, parity}) && data_s) byte_valid  <= 1'b1;
              else                                  frame_error <= 1'b1;
              state <= FR_IDLE;
            end
            default: state <= FR_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame reception plus make/break/extended decoding
// into a held keycode for the snake-game master controller.
//   clk100MHz    : system clock
//   rst_n        : async active-low reset
//   ps2Clk/Data  : raw keyboard lines
//   keycode      : last make code, cleared by its own break; 00 = no key
//   extended     : keycode came from an E0-prefixed sequence
//   newKeyStrobe : one-cycle pulse on every make (including typematic repeats)
//   frameError   : one-cycle pulse on a bad or timed-out frame
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk100MHz,
  input  logic       rst_n,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       newKeyStrobe,
  output logic       frameError
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  dec_state_t dec_state;
  logic [2:0] skip_cnt;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .clk        (clk100MHz),
    .rst_n      (rst_n),
    .ps2_clk    (ps2Clk),
    .ps2_data   (ps2Data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .frame_error(frameError)
  );

  // Scan-code sequence decoder
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      dec_state    <= DEC_BASE;
      skip_cnt     <= '0;
      keycode      <= 8'h00;
      extended     <= 1'b0;
      newKeyStrobe <= 1'b0;
    end else begin
      newKeyStrobe <= 1'b0;
      if (rx_valid) begin
        case (dec_state)
          DEC_BASE: begin
            if (rx_byte == PFX_EXT) begin
              dec_state <= DEC_EXT;
            end else if (rx_byte == PFX_BRK) begin
              dec_state <= DEC_BRK;
            end else if (rx_byte == PFX_PAUSE) begin
              dec_state <= DEC_SKIP;
              skip_cnt  <= PAUSE_SKIP_LEN;
            end else if (!is_ignore_code(rx_byte)) begin
              keycode      <= rx_byte;
              extended     <= 1'b0;
              newKeyStrobe <= 1'b1;
            end
          end
          DEC_EXT: begin
            if (rx_byte == PFX_BRK) begin
              dec_state <= DEC_EXT_BRK;
            end else begin
              keycode      <= rx_byte;
              extended     <= 1'b1;
              newKeyStrobe <= 1'b1;
              dec_state    <= DEC_BASE;
            end
          end
          // A break only releases the key if it names the held key exactly
          DEC_BRK: begin
            if (rx_byte == keycode && !extended) begin
              keycode  <= 8'h00;
              extended <= 1'b0;
            end
            dec_state <= DEC_BASE;
          end
          DEC_EXT_BRK: begin
            if (rx_byte == keycode && extended) begin
              keycode  <= 8'h00;
              extended <= 1'b0;
            end
            dec_state <= DEC_BASE;
          end
          DEC_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) dec_state <= DEC_BASE;
          end
          default: dec_state <= DEC_BASE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios followed by
// random scan-code streams checked against a flag-based key model.
module tb_ps2_key_receiver;

  localparam int TO    = 400;  // shortened timeout for simulation
  localparam int HALF  = 20;   // half PS/2 bit period in system clocks
  localparam int PIPE  = 10;   // sync + filter depth
  localparam int GAP   = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] keycode;
  logic       extended;
  logic       newKeyStrobe;
  logic       frameError;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int strobe_q[$];
  int err_q[$];

  // Reference model of held-key state
  logic [7:0] m_key;
  bit         m_ext;
  bit         m_ext_pend;
  bit         m_brk_pend;
  int         m_skip;

  ps2_key_receiver #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk100MHz   (clk),
    .rst_n       (rst_n),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .keycode     (keycode),
    .extended    (extended),
    .newKeyStrobe(newKeyStrobe),
    .frameError  (frameError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (newKeyStrobe) strobe_q.push_back(cyc);
    if (frameError)   err_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_key = 8'h00; m_ext = 0; m_ext_pend = 0; m_brk_pend = 0; m_skip = 0;
  endtask

  function automatic bit ignorable(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE;
  endfunction

  // Applies one good byte to the model; strobe set when a make is expected
  task automatic model_byte(input logic [7:0] b, output bit strobe);
    strobe = 0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk_pend) begin
      if (b == m_key && m_ext == m_ext_pend) begin
        m_key = 8'h00;
        m_ext = 0;
      end
      m_brk_pend = 0;
      m_ext_pend = 0;
    end else if (b == 8'hF0) begin
      m_brk_pend = 1;
    end else if (!m_ext_pend && b == 8'hE0) begin
      m_ext_pend = 1;
    end else if (!m_ext_pend && b == 8'hE1) begin
      m_skip = 7;
    end else if (!m_ext_pend && ignorable(b)) begin
      strobe = 0;
    end else begin
      m_key = b;
      m_ext = m_ext_pend;
      m_ext_pend = 0;
      strobe = 1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2Data = b;
    wait_cycles(HALF);
    ps2Clk = 1'b0;
    last_fall = cyc;
    wait_cycles(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1 ^ bad_stop);
    ps2Data = 1'b1;
    wait_cycles(GAP);
  endtask

  // Sends one frame and checks key state, strobe count and error count
  task automatic frame_check(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit exp_s;
    bit bad;
    bad = bad_par | bad_stop;
    strobe_q.delete();
    err_q.delete();
    send_frame(b, bad_par, bad_stop);
    exp_s = 0;
    if (!bad) model_byte(b, exp_s);
    chk("keycode", keycode, m_key);
    chk("extended", extended, m_ext);
    chk("strobe_count", strobe_q.size(), exp_s);
    chk("error_count", err_q.size(), bad);
  endtask

  initial begin
    int lat;
    logic [7:0] tbl [14];
    tbl = '{8'h1B, 8'h4D, 8'h2D, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74,
            8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'hFA};
    rst_n = 1'b0;
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    model_reset();
    wait_cycles(5);
    chk("rst_keycode", keycode, 8'h00);
    chk("rst_extended", extended, 1'b0);
    chk("rst_strobe", newKeyStrobe, 1'b0);
    chk("rst_frame_error", frameError, 1'b0);
    rst_n = 1'b1;
    wait_cycles(10);

    // Make 1B; strobe one cycle, about two cycles after the stop sample
    frame_check(8'h1B, 0, 0);
    lat = (strobe_q.size() > 0) ? strobe_q[0] - last_fall : -1;
    chk("strobe_latency_in_window", (lat >= PIPE && lat <= PIPE + 4), 1'b1);

    // Break of the held key releases it
    frame_check(8'hF0, 0, 0);
    frame_check(8'h1B, 0, 0);
    // Break of a different key leaves the held key
    frame_check(8'h1B, 0, 0);
    frame_check(8'h1B, 0, 0);  // typematic repeat strobes again
    frame_check(8'hF0, 0, 0);
    frame_check(8'h2D, 0, 0);
    chk("held_after_other_break", keycode, 8'h1B);

    // Extended make and extended break
    frame_check(8'hE0, 0, 0);
    frame_check(8'h75, 0, 0);
    chk("ext_make_key", keycode, 8'h75);
    chk("ext_make_flag", extended, 1'b1);
    frame_check(8'hE0, 0, 0);
    frame_check(8'hF0, 0, 0);
    frame_check(8'h75, 0, 0);
    chk("ext_break_key", keycode, 8'h00);

    // Parity and stop errors leave key state alone
    frame_check(8'h72, 0, 0);
    frame_check(8'h4D, 1, 0);
    chk("after_parity_error", keycode, 8'h72);
    frame_check(8'h76, 0, 0);
    frame_check(8'h6B, 0, 1);
    chk("after_stop_error", keycode, 8'h76);

    // Timeout after four data bits
    strobe_q.delete();
    err_q.delete();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2Data = 1'b1;
    wait_cycles(TO + 40);
    chk("timeout_error_count", err_q.size(), 1);
    lat = (err_q.size() > 0) ? err_q[0] - last_fall : -1;
    chk("timeout_latency_in_window", (lat >= TO + PIPE && lat <= TO + PIPE + 4), 1'b1);
    chk("timeout_no_strobe", strobe_q.size(), 0);
    frame_check(8'h2D, 0, 0);

    // Short low glitch on the clock with data low must not start a frame
    strobe_q.delete();
    err_q.delete();
    ps2Data = 1'b0;
    ps2Clk = 1'b0;
    wait_cycles(5);
    ps2Clk = 1'b1;
    wait_cycles(2);
    ps2Data = 1'b1;
    wait_cycles(GAP);
    frame_check(8'h74, 0, 0);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    rst_n = 1'b0;
    model_reset();
    wait_cycles(3);
    chk("midframe_rst_keycode", keycode, 8'h00);
    rst_n = 1'b1;
    wait_cycles(20);
    frame_check(8'h1B, 0, 0);

    // Random scan-code stream
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [7:0] b;
      bit bad;
      sel = $urandom_range(0, 15);
      bad = ($urandom_range(0, 9) == 0);
      if (sel < 14) begin
        b = tbl[sel];
        frame_check(b, bad, 0);
      end else if (sel == 14) begin
        b = m_key;
        frame_check(8'hF0, 0, 0);
        frame_check(b, 0, 0);
      end else begin
        b = 8'($urandom);
        frame_check(b, bad, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
